// File: rtl/class_score_packer.sv
// Serial-to-parallel class score packer: requantizes signed per-class scores to
// unsigned bytes and publishes a complete frame as one flat vector with a valid pulse.
module class_score_packer #(
   parameter int NUM_CLASS = 24,
   parameter int IN_W      = 16,
   parameter int OUT_W     = 8,
   parameter int SHIFT     = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [IN_W-1:0]            score_i,
   input  logic                       score_valid_i,
   input  logic                       sof_i,
   output logic                       score_ready_o,
   output logic [NUM_CLASS*OUT_W-1:0] data_out,
   output logic                       valid_o,
   output logic                       frame_err_o
);

   localparam int CNT_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CLASS - 1);
   localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << OUT_W) - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] PUBLISH = 2'd2;

   logic [1:0]                       state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [NUM_CLASS-1:0][OUT_W-1:0]  buf_q, buf_d;
   logic [NUM_CLASS*OUT_W-1:0]       data_q, data_d;
   logic                             valid_q, valid_d;
   logic                             err_q, err_d;

   logic                             accept;
   logic                             wr_en;
   logic [CNT_W-1:0]                 wr_idx;
   logic [OUT_W-1:0]                 rq;

   // Arithmetic shift, then clamp to [0, 2^OUT_W-1].
   function automatic logic [OUT_W-1:0] requant(input logic signed [IN_W-1:0] s);
      logic signed [IN_W-1:0] q;
      q = s >>> SHIFT;
      if (q < 0)
         requant = '0;
      else if (q > SAT_MAX)
         requant = '1;
      else
         requant = q[OUT_W-1:0];
   endfunction

   assign score_ready_o = (state_q != PUBLISH);
   assign accept        = score_valid_i && score_ready_o;
   assign rq            = requant($signed(score_i));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (sof_i) begin
                  wr_en   = 1'b1;
                  cnt_d   = CNT_W'(1);
                  state_d = COLLECT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (accept) begin
               wr_en = 1'b1;
               if (sof_i) begin
                  // Restart: stale slots are all rewritten before the next publish.
                  err_d = 1'b1;
                  cnt_d = CNT_W'(1);
               end else begin
                  wr_idx = cnt_q;
                  if (cnt_q == LAST_SLOT) begin
                     cnt_d   = '0;
                     state_d = PUBLISH;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         PUBLISH: begin
            data_d  = buf_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      buf_d = buf_q;
      for (int j = 0; j < NUM_CLASS; j++) begin
         if (wr_en && (wr_idx == CNT_W'(j)))
            buf_d[j] = rq;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign data_out    = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = err_q;

endmodule

// File: tb/tb_class_score_packer.sv
// Directed bench for class_score_packer: stimulus pushes expected frames and error
// pulses into queues; a monitor pops and compares whenever the DUT presents them.
module tb_class_score_packer;

   localparam int NC = 24;
   localparam int DW = NC * 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic [15:0]   score_i;
   logic          score_valid_i;
   logic          sof_i;
   logic          score_ready_o;
   logic [DW-1:0] data_out;
   logic          valid_o;
   logic          frame_err_o;

   class_score_packer #(.NUM_CLASS(NC), .IN_W(16), .OUT_W(8), .SHIFT(4)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .score_i       (score_i),
      .score_valid_i (score_valid_i),
      .sof_i         (sof_i),
      .score_ready_o (score_ready_o),
      .data_out      (data_out),
      .valid_o       (valid_o),
      .frame_err_o   (frame_err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      int            vcyc;
   } exp_t;

   exp_t          exp_q[$];
   int            err_q[$];
   logic [DW-1:0] hold;
   logic [15:0]   sc[NC];
   logic [DW-1:0] ex;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      int   ec;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            hold = '0;
            chk("rst_data", data_out, '0);
            chk("rst_valid", DW'(valid_o), '0);
            chk("rst_err", DW'(frame_err_o), '0);
            chk("rst_ready", DW'(score_ready_o), DW'(1));
         end else begin
            if (valid_o) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_valid", DW'(valid_o), '0);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_data", data_out, e.data);
                  chk("valid_cycle", DW'(cyc), DW'(e.vcyc));
                  hold = e.data;
               end
            end else begin
               chk("data_hold", data_out, hold);
            end
            if (frame_err_o) begin
               if (err_q.size() == 0) begin
                  chk("spurious_err", DW'(frame_err_o), '0);
               end else begin
                  ec = err_q.pop_front();
                  chk("err_cycle", DW'(cyc), DW'(ec));
               end
            end
         end
      end
   endtask

   // Offer one beat; returns the cycle in which it was accepted.
   task automatic beat(input logic [15:0] s, input logic sof, output int acc);
      logic ok;
      int   tries;
      score_i       = s;
      sof_i         = sof;
      score_valid_i = 1'b1;
      tries         = 0;
      acc           = -1;
      do begin
         @(negedge clk);
         ok  = score_ready_o;
         acc = cyc;
         @(posedge clk);
         #1;
         tries++;
      end while (!ok && tries < 20);
      if (!ok) chk("ready_timeout", DW'(score_ready_o), DW'(1));
   endtask

   task automatic idle(input int n);
      score_valid_i = 1'b0;
      sof_i         = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sends sc[] as a full frame and expects ex to be published.
   task automatic send_frame(input logic err_on_first, output int first, output int last);
      int a;
      first = 0;
      last  = 0;
      for (int j = 0; j < NC; j++) begin
         beat(sc[j], (j == 0), a);
         if (j == 0) begin
            first = a;
            if (err_on_first) err_q.push_back(a + 1);
         end
         if (j == NC - 1) begin
            last = a;
            exp_q.push_back('{data: ex, vcyc: a + 2});
         end
      end
   endtask

   task automatic run_stim();
      int f0, l0, f1, l1, a;
      resetn        = 1'b0;
      score_i       = '0;
      score_valid_i = 1'b0;
      sof_i         = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      idle(2);

      // Ramp frame: slot j = j, back-to-back beats.
      ex = '0;
      for (int j = 0; j < NC; j++) begin
         sc[j] = 16'(j << 4);
         ex[j*8 +: 8] = 8'(j);
      end
      send_frame(1'b0, f0, l0);
      chk("ramp_backtoback", DW'(l0 - f0), DW'(NC - 1));
      idle(4);

      // Saturation corners.
      ex = '0;
      for (int j = 0; j < NC; j++) sc[j] = 16'h0000;
      sc[0] = 16'h0FF0;
      sc[1] = 16'h1000;
      sc[2] = 16'hFFF0;
      sc[3] = 16'h0123;
      ex[7:0]   = 8'hFF;
      ex[15:8]  = 8'hFF;
      ex[23:16] = 8'h00;
      ex[31:24] = 8'h12;
      send_frame(1'b0, f0, l0);
      idle(4);

      // Two stray non-sof beats in IDLE, then a good frame.
      beat(16'h0100, 1'b0, a);
      err_q.push_back(a + 1);
      beat(16'h0200, 1'b0, a);
      err_q.push_back(a + 1);
      idle(3);
      ex = '0;
      for (int j = 0; j < NC; j++) begin
         sc[j] = 16'((200 - j) << 4);
         ex[j*8 +: 8] = 8'(200 - j);
      end
      send_frame(1'b0, f0, l0);
      idle(4);

      // sof reasserted at beat 10 restarts the frame.
      beat(16'h0FF0, 1'b1, a);
      for (int j = 1; j < 10; j++) beat(16'h0FF0, 1'b0, a);
      ex = '0;
      for (int j = 0; j < NC; j++) begin
         sc[j] = 16'((j + 30) << 4);
         ex[j*8 +: 8] = 8'(j + 30);
      end
      send_frame(1'b1, f0, l0);
      idle(4);

      // Back-to-back frames: second sof is stalled by PUBLISH.
      ex = '0;
      for (int j = 0; j < NC; j++) begin
         sc[j] = 16'((2 * j + 1) << 4);
         ex[j*8 +: 8] = 8'(2 * j + 1);
      end
      send_frame(1'b0, f0, l0);
      ex = '0;
      for (int j = 0; j < NC; j++) begin
         sc[j] = 16'((255 - j) << 4);
         ex[j*8 +: 8] = 8'(255 - j);
      end
      send_frame(1'b0, f1, l1);
      chk("b2b_accept_cycle", DW'(f1), DW'(l0 + 2));
      chk("frame_period", DW'(f1 - f0), DW'(NC + 1));
      idle(4);

      // Reset after 15 beats loses the partial frame.
      beat(16'h0330, 1'b1, a);
      for (int j = 1; j < 15; j++) beat(16'h0330, 1'b0, a);
      score_valid_i = 1'b0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      idle(5);
      ex = '0;
      for (int j = 0; j < NC; j++) begin
         sc[j] = 16'h0550;
         ex[j*8 +: 8] = 8'h55;
      end
      send_frame(1'b0, f0, l0);
      idle(6);

      chk("pending_frames", DW'(exp_q.size()), '0);
      chk("pending_errs", DW'(err_q.size()), '0);
   endtask

   initial begin
      fork
         monitor();
         run_stim();
         begin
            #200000;
            errors++;
            $display("FAIL watchdog: simulation time limit reached");
         end
      join_any
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
